// File: rtl/pkt_filter_csr.sv
// Purpose: CSR block for the packet filter; holds shadow/active pattern and enable, commits only between packets.
// Latency: reads return 1 cycle after amm_read_i; a commit becomes visible on cfg_* the cycle after its edge.
// Backpressure: writes stall on amm_waitrequest_o while a commit is pending; reads never stall.
// Optional feature: define PKT_FILTER_MATCH_CNT_EN to build the 32-bit saturating match counter at address 4.
module pkt_filter_csr #(
    parameter int AMM_DWIDTH = 32,
    parameter int AMM_AWIDTH = 3,
    parameter int STR_LEN    = 12
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [AMM_AWIDTH-1:0]   amm_address_i,
    input  logic                    amm_write_i,
    input  logic [AMM_DWIDTH-1:0]   amm_writedata_i,
    input  logic [AMM_DWIDTH/8-1:0] amm_byteenable_i,
    input  logic                    amm_read_i,
    output logic [AMM_DWIDTH-1:0]   amm_readdata_o,
    output logic                    amm_readdatavalid_o,
    output logic                    amm_waitrequest_o,
    input  logic                    ast_valid_i,
    input  logic                    ast_ready_i,
    input  logic                    ast_startofpacket_i,
    input  logic                    ast_endofpacket_i,
    input  logic                    match_i,
    output logic                    cfg_enable_o,
    output logic [STR_LEN*8-1:0]    cfg_pattern_o
);
    localparam int BYTES  = AMM_DWIDTH / 8;
    localparam int NWORDS = STR_LEN * 8 / AMM_DWIDTH;
    localparam logic [AMM_AWIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [AMM_AWIDTH-1:0] ADDR_CNT  = AMM_AWIDTH'(4);

    typedef enum logic {IDLE, IN_PKT} pkt_state_t;

    pkt_state_t               state;
    pkt_state_t               state_nxt;
    logic                     shadow_en;
    logic [STR_LEN*8-1:0]     shadow_pat;
    logic                     active_en;
    logic [STR_LEN*8-1:0]     active_pat;
    logic                     pending;
    logic                     sop_beat;
    logic                     eop_beat;
    logic                     wr_acc;
    logic                     commit;
    logic [AMM_DWIDTH-1:0]    rd_val;
    logic [AMM_DWIDTH-1:0]    rd_dat;
    logic                     rd_vld;

    assign sop_beat = ast_valid_i & ast_ready_i & ast_startofpacket_i;
    assign eop_beat = ast_valid_i & ast_ready_i & ast_endofpacket_i;

    // Any write is held off while a commit is outstanding so the shadow copy cannot change under it.
    assign amm_waitrequest_o = amm_write_i & pending & ~srst_i;
    assign wr_acc            = amm_write_i & ~amm_waitrequest_o;

    // A sop beat in IDLE means a packet starts on this edge, so the commit waits for the packet to end.
    assign commit = (state == IDLE) & pending & ~sop_beat;

    assign cfg_enable_o        = active_en;
    assign cfg_pattern_o       = active_pat;
    assign amm_readdata_o      = rd_dat;
    assign amm_readdatavalid_o = rd_vld;

    // Packet state register.
    always_ff @(posedge clk_i) begin
        if (srst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Packet tracking; eop in IDLE and sop in IN_PKT are protocol errors and are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (sop_beat && !eop_beat) state_nxt = IN_PKT;
            IN_PKT: if (eop_beat)              state_nxt = IDLE;
        endcase
    end

    // Shadow registers, pending flag and the shadow-to-active commit.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            shadow_en  <= 1'b0;
            shadow_pat <= '0;
            active_en  <= 1'b0;
            active_pat <= '0;
            pending    <= 1'b0;
        end else begin
            if (commit) begin
                active_en  <= shadow_en;
                active_pat <= shadow_pat;
                pending    <= 1'b0;
            end
            if (wr_acc && amm_address_i == ADDR_CTRL) begin
                shadow_en <= amm_writedata_i[0];
                if (amm_writedata_i[1]) pending <= 1'b1;
            end
            for (int w = 0; w < NWORDS; w++) begin
                if (wr_acc && amm_address_i == AMM_AWIDTH'(w + 1)) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (amm_byteenable_i[b])
                            shadow_pat[(w*BYTES+b)*8 +: 8] <= amm_writedata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef PKT_FILTER_MATCH_CNT_EN
    logic [31:0] match_cnt;

    // Saturating hit counter; a write to its address clears it and wins over a coincident hit.
    always_ff @(posedge clk_i) begin
        if (srst_i)
            match_cnt <= '0;
        else if (wr_acc && amm_address_i == ADDR_CNT)
            match_cnt <= '0;
        else if (match_i && active_en && match_cnt != 32'hFFFF_FFFF)
            match_cnt <= match_cnt + 32'd1;
    end
`else
    logic unused_match;
    assign unused_match = match_i;
`endif

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (amm_address_i == ADDR_CTRL)
            rd_val[2:0] = {state == IN_PKT, pending, shadow_en};
        for (int w = 0; w < NWORDS; w++) begin
            if (amm_address_i == AMM_AWIDTH'(w + 1))
                rd_val = shadow_pat[w*AMM_DWIDTH +: AMM_DWIDTH];
        end
`ifdef PKT_FILTER_MATCH_CNT_EN
        if (amm_address_i == ADDR_CNT)
            rd_val = AMM_DWIDTH'(match_cnt);
`endif
    end

    // Registered read response; data is zero whenever valid is low.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rd_vld <= 1'b0;
            rd_dat <= '0;
        end else begin
            rd_vld <= amm_read_i;
            rd_dat <= amm_read_i ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_pkt_filter_csr.sv
// Bench for pkt_filter_csr: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a byte-level behavioural model of the register block.
module tb_pkt_filter_csr;
    logic        clk = 1'b0;
    logic        srst_i;
    logic [2:0]  amm_address_i;
    logic        amm_write_i;
    logic [31:0] amm_writedata_i;
    logic [3:0]  amm_byteenable_i;
    logic        amm_read_i;
    logic [31:0] amm_readdata_o;
    logic        amm_readdatavalid_o;
    logic        amm_waitrequest_o;
    logic        ast_valid_i, ast_ready_i, ast_startofpacket_i, ast_endofpacket_i, match_i;
    logic        cfg_enable_o;
    logic [95:0] cfg_pattern_o;

    pkt_filter_csr dut (
        .clk_i(clk), .srst_i(srst_i),
        .amm_address_i(amm_address_i), .amm_write_i(amm_write_i),
        .amm_writedata_i(amm_writedata_i), .amm_byteenable_i(amm_byteenable_i),
        .amm_read_i(amm_read_i), .amm_readdata_o(amm_readdata_o),
        .amm_readdatavalid_o(amm_readdatavalid_o), .amm_waitrequest_o(amm_waitrequest_o),
        .ast_valid_i(ast_valid_i), .ast_ready_i(ast_ready_i),
        .ast_startofpacket_i(ast_startofpacket_i), .ast_endofpacket_i(ast_endofpacket_i),
        .match_i(match_i), .cfg_enable_o(cfg_enable_o), .cfg_pattern_o(cfg_pattern_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_on = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned m_sh[12];
    byte unsigned m_act[12];
    bit           m_sh_en, m_act_en, m_pend, m_inpkt, m_rdv, m_acc;
    logic [31:0]  m_rd;
    int unsigned  m_cnt;
    bit           sop_b, eop_b, wr_ok, do_commit;
    logic [31:0]  rv;
    int           ma;

    function automatic logic [95:0] act_vec();
        logic [95:0] v;
        for (int i = 0; i < 12; i++) v[i*8 +: 8] = m_act[i];
        return v;
    endfunction

    always @(posedge clk) begin
        ma    = int'(amm_address_i);
        sop_b = ast_valid_i && ast_ready_i && ast_startofpacket_i;
        eop_b = ast_valid_i && ast_ready_i && ast_endofpacket_i;
        rv = 32'd0;
        if (ma == 0) rv = {29'd0, m_inpkt, m_pend, m_sh_en};
        else if (ma >= 1 && ma <= 3)
            rv = {m_sh[4*(ma-1)+3], m_sh[4*(ma-1)+2], m_sh[4*(ma-1)+1], m_sh[4*(ma-1)]};
`ifdef PKT_FILTER_MATCH_CNT_EN
        else if (ma == 4) rv = m_cnt;
`endif
        if (srst_i) begin
            for (int i = 0; i < 12; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            m_sh_en = 0; m_act_en = 0; m_pend = 0; m_inpkt = 0; m_cnt = 0;
            m_rdv = 0; m_rd = 0; m_acc = 1;
        end else begin
            wr_ok     = amm_write_i && !m_pend;
            m_acc     = wr_ok;
            do_commit = !m_inpkt && m_pend && !sop_b;
            if (wr_ok && ma == 4) m_cnt = 0;
            else if (match_i && m_act_en && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (do_commit) begin
                m_act = m_sh; m_act_en = m_sh_en; m_pend = 0;
            end
            if (wr_ok && ma == 0) begin
                m_sh_en = amm_writedata_i[0];
                if (amm_writedata_i[1]) m_pend = 1;
            end
            if (wr_ok && ma >= 1 && ma <= 3)
                for (int b = 0; b < 4; b++)
                    if (amm_byteenable_i[b]) m_sh[4*(ma-1)+b] = amm_writedata_i[b*8 +: 8];
            if (!m_inpkt) begin
                if (sop_b && !eop_b) m_inpkt = 1;
            end else if (eop_b) m_inpkt = 0;
            m_rdv = amm_read_i;
            m_rd  = amm_read_i ? rv : 32'd0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_cfg_enable", cfg_enable_o, m_act_en);
            chk("m_cfg_pattern", cfg_pattern_o, act_vec());
            chk("m_readdatavalid", amm_readdatavalid_o, m_rdv);
            chk("m_readdata", amm_readdata_o, m_rd);
            chk("m_waitrequest", amm_waitrequest_o, amm_write_i && m_pend && !srst_i);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bit done = 0;
        amm_address_i = a; amm_writedata_i = d; amm_byteenable_i = be; amm_write_i = 1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!amm_waitrequest_o) done = 1;
            tick();
        end
        amm_write_i = 0;
        if (!done) begin
            n_total++;
            $display("FAIL write_timeout: addr %0d still stalled after 64 cycles, expected completion", a);
        end
    endtask

    task automatic csr_read_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        amm_address_i = a; amm_read_i = 1;
        tick();
        amm_read_i = 0;
        @(negedge clk);
        chk({name, "_rdv"}, amm_readdatavalid_o, 1'b1);
        chk(name, amm_readdata_o, exp);
        tick();
    endtask

    task automatic beat(input bit sop, input bit eop);
        ast_valid_i = 1; ast_ready_i = 1; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
        tick();
        ast_valid_i = 0; ast_startofpacket_i = 0; ast_endofpacket_i = 0;
    endtask

    localparam logic [95:0] P_ABC  = 96'h6C6B6A69_68676665_64636261;
    localparam logic [95:0] P_NEW1 = 96'h6C6B6A69_68676665_00BB00DD;
    localparam logic [95:0] P_NEW2 = 96'h6C6B6A69_68676665_11223344;

    initial begin
        srst_i = 1; amm_address_i = 0; amm_write_i = 0; amm_writedata_i = 0;
        amm_byteenable_i = 0; amm_read_i = 0; ast_valid_i = 0; ast_ready_i = 0;
        ast_startofpacket_i = 0; ast_endofpacket_i = 0; match_i = 0;
        repeat (3) @(posedge clk);
        #1 srst_i = 0; cmp_on = 1;

        // Reset state
        @(negedge clk);
        chk("rst_enable", cfg_enable_o, 1'b0);
        chk("rst_pattern", cfg_pattern_o, 96'd0);
        chk("rst_rdv", amm_readdatavalid_o, 1'b0);
        tick();
        csr_read_chk(3'd0, 32'd0, "rst_ctrl");

        // Pattern load and commit in IDLE
        csr_write(3'd1, 32'h64636261, 4'hF);
        csr_write(3'd2, 32'h68676665, 4'hF);
        csr_write(3'd3, 32'h6C6B6A69, 4'hF);
        csr_write(3'd0, 32'h3, 4'hF);
        @(negedge clk);
        chk("commit_not_yet", cfg_enable_o, 1'b0);
        tick();
        @(negedge clk);
        chk("commit_enable", cfg_enable_o, 1'b1);
        chk("commit_pattern", cfg_pattern_o, P_ABC);
        tick();
        csr_read_chk(3'd0, 32'h1, "commit_ctrl");

        // Byte-enabled pattern write
        csr_write(3'd1, 32'h0, 4'hF);
        csr_write(3'd1, 32'hAABBCCDD, 4'h5);
        csr_read_chk(3'd1, 32'h00BB00DD, "byteen_rd");
        @(negedge clk);
        chk("byteen_rdv_once", amm_readdatavalid_o, 1'b0);
        tick();

        // Commit deferred for a packet in flight; pattern write stalls meanwhile
        beat(1, 0);
        csr_read_chk(3'd0, 32'h5, "inpkt_ctrl");
        csr_write(3'd0, 32'h3, 4'hF);
        amm_address_i = 3'd1; amm_writedata_i = 32'h11223344; amm_byteenable_i = 4'hF; amm_write_i = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_wait", amm_waitrequest_o, 1'b1);
            chk("stall_cfg", cfg_pattern_o, P_ABC);
            tick();
        end
        ast_valid_i = 1; ast_ready_i = 1; ast_endofpacket_i = 1;
        @(negedge clk);
        chk("eop_wait", amm_waitrequest_o, 1'b1);
        tick();
        ast_valid_i = 0; ast_endofpacket_i = 0;
        @(negedge clk);
        chk("idle_wait", amm_waitrequest_o, 1'b1);
        chk("idle_cfg", cfg_pattern_o, P_ABC);
        tick();
        @(negedge clk);
        chk("released_wait", amm_waitrequest_o, 1'b0);
        chk("released_cfg", cfg_pattern_o, P_NEW1);
        tick();
        amm_write_i = 0;
        csr_read_chk(3'd1, 32'h11223344, "stalled_wr_done");

        // CTRL write coinciding with a single-beat packet
        ast_valid_i = 1; ast_ready_i = 1; ast_startofpacket_i = 1; ast_endofpacket_i = 1;
        csr_write(3'd0, 32'h3, 4'hF);
        ast_valid_i = 0; ast_startofpacket_i = 0; ast_endofpacket_i = 0;
        amm_address_i = 3'd0; amm_read_i = 1;
        @(negedge clk);
        chk("se_pre_cfg", cfg_pattern_o, P_NEW1);
        tick();
        amm_read_i = 0;
        @(negedge clk);
        chk("se_ctrl_preedge", amm_readdata_o, 32'h3);
        chk("se_post_cfg", cfg_pattern_o, P_NEW2);
        tick();
        csr_read_chk(3'd0, 32'h1, "se_ctrl_after");

        // Counter address (clears or ignored) and unmapped addresses
        csr_write(3'd4, 32'hDEADBEEF, 4'hF);
        csr_read_chk(3'd4, 32'd0, "cnt_addr");
        csr_write(3'd5, 32'hFFFFFFFF, 4'hF);
        csr_read_chk(3'd5, 32'd0, "addr5");
        csr_read_chk(3'd7, 32'd0, "addr7");

`ifdef PKT_FILTER_MATCH_CNT_EN
        dut.match_cnt = 32'hFFFF_FFFD;
        m_cnt = 32'hFFFF_FFFD;
        match_i = 1;
        repeat (3) tick();
        match_i = 0;
        csr_read_chk(3'd4, 32'hFFFF_FFFF, "cnt_sat");
        match_i = 1;
        csr_write(3'd4, 32'h0, 4'hF);
        match_i = 0;
        csr_read_chk(3'd4, 32'd0, "cnt_clear_wins");
`endif

        // Reset mid-packet with a pending commit and a stalled write
        beat(1, 0);
        csr_write(3'd0, 32'h2, 4'hF);
        amm_address_i = 3'd2; amm_writedata_i = 32'h55555555; amm_byteenable_i = 4'hF; amm_write_i = 1;
        @(negedge clk);
        chk("pre_rst_wait", amm_waitrequest_o, 1'b1);
        tick();
        srst_i = 1;
        @(negedge clk);
        chk("in_rst_wait", amm_waitrequest_o, 1'b0);
        tick();
        srst_i = 0; amm_write_i = 0;
        @(negedge clk);
        chk("post_rst_enable", cfg_enable_o, 1'b0);
        chk("post_rst_pattern", cfg_pattern_o, 96'd0);
        chk("post_rst_rdv", amm_readdatavalid_o, 1'b0);
        tick();
        csr_read_chk(3'd0, 32'd0, "post_rst_ctrl");
        beat(0, 1);
        csr_read_chk(3'd0, 32'd0, "stray_eop_ctrl");
        beat(1, 0);
        beat(1, 0);
        csr_read_chk(3'd0, 32'h4, "stray_sop_ctrl");
        beat(0, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            srst_i              = ($urandom_range(0, 399) == 0);
            ast_valid_i         = $urandom_range(0, 1);
            ast_ready_i         = ($urandom_range(0, 3) != 0);
            ast_startofpacket_i = ($urandom_range(0, 4) == 0);
            ast_endofpacket_i   = ($urandom_range(0, 3) == 0);
            match_i             = $urandom_range(0, 1);
            if (!(amm_write_i && !m_acc)) begin
                amm_write_i = 0; amm_read_i = 0;
                case ($urandom_range(0, 9))
                    0, 1, 2: begin
                        amm_write_i      = 1;
                        amm_address_i    = 3'($urandom_range(0, 7));
                        amm_writedata_i  = $urandom;
                        amm_byteenable_i = 4'($urandom_range(0, 15));
                    end
                    3, 4, 5: begin
                        amm_read_i    = 1;
                        amm_address_i = 3'($urandom_range(0, 7));
                    end
                    default: ;
                endcase
            end
        end
        tick();
        amm_write_i = 0; amm_read_i = 0; srst_i = 0; ast_valid_i = 0; match_i = 0;
        repeat (3) tick();
        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
